memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
//  RV32I MEM pipeline stage, directly downstream of execute_stage (consumes control_out, alu_data, memory_data).
//  Performs data-memory load/store over a req/gnt/rvalid handshake with variable latency.
//  Applies byte-lane strobes and load sign/zero extension.
//  Registers results for writeback; raises stall while a memory access is outstanding.
// PARAMETERS
//  DMEM_AW   12   byte-address bits driven on dmem_addr (alu_data[DMEM_AW-1:0])
// PORTS
//  clk             in   1        clock; all state updates on rising edge
//  rst             in   1        synchronous reset, active-high
//  in_valid        in   1        execute-stage outputs valid this cycle
//  control_in      in   control_type  control from execute (MemRead, MemWrite, RegWrite, MemtoReg used)
//  funct3          in   3        access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  rd_in           in   5        destination register
//  alu_data        in   32       ALU result; byte address for loads/stores
//  memory_data     in   32       store data (rs2)
//  stall           out  1        high while state != IDLE; upstream holds its outputs
//  dmem_req        out  1        memory request, held until dmem_gnt
//  dmem_we         out  1        1 = write
//  dmem_addr       out  DMEM_AW  word-aligned address ({addr[DMEM_AW-1:2],2'b00})
//  dmem_wstrb      out  4        byte-lane write strobes
//  dmem_wdata      out  32       lane-replicated store data
//  dmem_gnt        in   1        request accepted this cycle
//  dmem_rvalid     in   1        read data valid (load only, >=1 cycle after gnt)
//  dmem_rdata      in   32       read word
//  wb_valid        out  1        one-cycle pulse: writeback bundle valid
//  wb_RegWrite     out  1        register-file write enable
//  wb_MemtoReg     out  1        select wb_mem_data vs wb_alu_data
//  wb_rd           out  5        destination register
//  wb_alu_data     out  32       pass-through ALU result
//  wb_mem_data     out  32       extended load data (0 for non-loads)
//  misaligned_err  out  1        pulses with wb_valid on misaligned or illegal-funct3 memory op
// BEHAVIOUR
//  FSM states: IDLE, REQ, RESP. Reset (sync, rst=1) -> IDLE.
//  Reset values: stall, dmem_*, wb_*, misaligned_err all 0.
//  IDLE, in_valid=0: wb_valid=0 next cycle.
//  IDLE, in_valid=1, no MemRead/MemWrite:
//   - latch bundle; next cycle wb_valid=1 with RegWrite/MemtoReg/rd/alu_data; wb_mem_data=0.
//   - 1-cycle latency; FSM stays IDLE.
//  IDLE, in_valid=1, mem op, misaligned (H: a[0]=1; W: a[1:0]!=0; funct3 not listed):
//   - no request; next cycle wb_valid=1, misaligned_err=1, wb_RegWrite=0.
//  IDLE, in_valid=1, legal mem op:
//   - latch addr/data/funct3/rd/control -> REQ; dmem_req=1 from next cycle.
//   - MemRead and MemWrite both set: treated as load.
//  Strobes:
//   - B: 4'b0001<<a[1:0]; H: 4'b0011<<{a[1],1'b0}; W: 4'b1111; loads: 0.
//   - wdata: B={4{d[7:0]}}, H={2{d[15:0]}}, W=d.
//  REQ: dmem_req/we/addr/wstrb/wdata stable until gnt.
//   - Store + gnt -> IDLE; next cycle wb_valid=1, wb_RegWrite=0.
//   - Load + gnt -> RESP.
//   - Request drops the cycle after gnt.
//  RESP: wait dmem_rvalid; rvalid outside RESP ignored.
//   - On rvalid, select lane by a[1:0] (H by a[1]).
//   - LB/LH sign-extend, LBU/LHU zero-extend.
//   - wb_mem_data registered, wb_valid=1 next cycle, -> IDLE.
//  stall = (state != IDLE); in_valid ignored while stall=1. Back-to-back accept resumes the cycle FSM returns to IDLE.
//  wb_valid is always a single-cycle pulse; other wb_* hold until the next pulse.
//  rst in REQ/RESP: abort; dmem_req=0 and no wb_valid for the aborted op; late rvalid ignored.
// TESTING
//  1 ALU op: in_valid, RegWrite=1, rd=5, alu_data=0x1234 -> next cycle wb_valid=1, wb_rd=5, wb_alu_data=0x1234, stall=0.
//  2 SB addr=0x103, data=0xAABBCCDD, gnt after 2 cycles -> wstrb=4'b1000, wdata=0xDDDDDDDD, addr=0x100, req held 3 cycles, wb_RegWrite=0.
//  3 LB addr=0x101, rdata=0x0000_8000, rvalid 3 cycles after gnt -> wb_mem_data=0xFFFFFF80; LBU same -> 0x00000080; stall high throughout.
//  4 LH addr=0x102, rdata=0x8001_0000 -> 0xFFFF8001; LW addr=0x102 -> no dmem_req, misaligned_err=1, wb_RegWrite=0.
//  5 rst asserted in RESP, then rvalid -> no wb_valid pulse, state IDLE, all outputs 0.
//  6 back-to-back: store then ALU op held by upstream under stall -> ALU wb_valid one cycle after store wb_valid.

Source files
------------

// File: rtl/memory_stage.sv
// memory_stage -- RV32I MEM pipeline stage.
// Issues data-memory loads/stores over a req/gnt/rvalid handshake with
// variable latency. It also builds byte-lane strobes and lane-replicated store
// data, and sign- or zero-extends load data. Results are registered for
// writeback, and stall stays high while an access is outstanding.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   in_valid        execute-stage bundle valid
//   control_in[3:0] {MemRead, MemWrite, RegWrite, MemtoReg}
//   funct3          000 B, 001 H, 010 W, 100 BU, 101 HU
//   rd_in           destination register
//   alu_data        ALU result / byte address
//   memory_data     store data (rs2)
//   stall           high while an access is in flight
//   dmem_req/we/addr/wstrb/wdata   memory request, held until dmem_gnt
//   dmem_gnt, dmem_rvalid, dmem_rdata   memory responses
//   wb_valid        single-cycle writeback pulse
//   wb_RegWrite, wb_MemtoReg, wb_rd, wb_alu_data, wb_mem_data   writeback bundle
//   misaligned_err  pulses with wb_valid for misaligned / illegal-funct3 ops
module memory_stage #(
  parameter int DMEM_AW = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [3:0]         control_in,
  input  logic [2:0]         funct3,
  input  logic [4:0]         rd_in,
  input  logic [31:0]        alu_data,
  input  logic [31:0]        memory_data,
  output logic               stall,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [3:0]         dmem_wstrb,
  output logic [31:0]        dmem_wdata,
  input  logic               dmem_gnt,
  input  logic               dmem_rvalid,
  input  logic [31:0]        dmem_rdata,
  output logic               wb_valid,
  output logic               wb_RegWrite,
  output logic               wb_MemtoReg,
  output logic [4:0]         wb_rd,
  output logic [31:0]        wb_alu_data,
  output logic [31:0]        wb_mem_data,
  output logic               misaligned_err
);

  localparam int C_MR  = 3;
  localparam int C_MW  = 2;
  localparam int C_RW  = 1;
  localparam int C_M2R = 0;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [31:0] alu_q, alu_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [2:0]  f3_q, f3_d;
  logic [4:0]  rd_q, rd_d;
  logic        regwrite_q, regwrite_d, memtoreg_q, memtoreg_d, load_q, load_d;
  logic        wb_valid_q, wb_valid_d, wb_rw_q, wb_rw_d, wb_m2r_q, wb_m2r_d;
  logic        wb_err_q, wb_err_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_alu_q, wb_alu_d, wb_mem_q, wb_mem_d;

  logic accept, is_mem, fault;

  // Illegal funct3 or a halfword/word not aligned to its size.
  function automatic logic mem_fault(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000, 3'b100: mem_fault = 1'b0;
      3'b001, 3'b101: mem_fault = a[0];
      3'b010:         mem_fault = (a != 2'b00);
      default:        mem_fault = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   store_strb = 4'b0001 << a;
      2'b01:   store_strb = 4'b0011 << {a[1], 1'b0};
      default: store_strb = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   store_data = {4{d[7:0]}};
      2'b01:   store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b100:  load_extend = {24'd0, b};
      3'b101:  load_extend = {16'd0, h};
      default: load_extend = w;
    endcase
  endfunction

  // in_valid is only looked at in IDLE, so upstream may hold its bundle under stall.
  assign accept = (state_q == IDLE) && in_valid;
  assign is_mem = control_in[C_MR] || control_in[C_MW];
  assign fault  = mem_fault(funct3, alu_data[1:0]);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_mem && !fault) state_d = REQ;
      REQ:     if (dmem_gnt) state_d = load_q ? RESP : IDLE;
      RESP:    if (dmem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: request fields are driven only while in REQ.
  always_comb begin
    stall      = (state_q != IDLE);
    dmem_req   = (state_q == REQ);
    dmem_we    = dmem_req && !load_q;
    dmem_addr  = dmem_req ? {alu_q[DMEM_AW-1:2], 2'b00} : '0;
    dmem_wstrb = dmem_req ? wstrb_q : 4'b0000;
    dmem_wdata = dmem_req ? wdata_q : 32'd0;
  end

  // Access latch and writeback bundle
  always_comb begin
    alu_d      = alu_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    f3_d       = f3_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    load_d     = load_q;
    wb_valid_d = 1'b0;
    wb_err_d   = 1'b0;
    wb_rw_d    = wb_rw_q;
    wb_m2r_d   = wb_m2r_q;
    wb_rd_d    = wb_rd_q;
    wb_alu_d   = wb_alu_q;
    wb_mem_d   = wb_mem_q;
    case (state_q)
      IDLE: begin
        if (accept && (!is_mem || fault)) begin
          // Non-memory op completes in one cycle; a faulting mem op reports
          // the error and must not write the register file.
          wb_valid_d = 1'b1;
          wb_err_d   = is_mem;
          wb_rw_d    = control_in[C_RW] && !is_mem;
          wb_m2r_d   = control_in[C_M2R];
          wb_rd_d    = rd_in;
          wb_alu_d   = alu_data;
          wb_mem_d   = 32'd0;
        end else if (accept) begin
          // MemRead wins when both MemRead and MemWrite are set.
          alu_d      = alu_data;
          f3_d       = funct3;
          rd_d       = rd_in;
          regwrite_d = control_in[C_RW];
          memtoreg_d = control_in[C_M2R];
          load_d     = control_in[C_MR];
          wstrb_d    = control_in[C_MR] ? 4'b0000 : store_strb(funct3, alu_data[1:0]);
          wdata_d    = control_in[C_MR] ? 32'd0 : store_data(funct3, memory_data);
        end
      end
      REQ: begin
        if (dmem_gnt && !load_q) begin
          wb_valid_d = 1'b1;
          wb_rw_d    = 1'b0;
          wb_m2r_d   = memtoreg_q;
          wb_rd_d    = rd_q;
          wb_alu_d   = alu_q;
          wb_mem_d   = 32'd0;
        end
      end
      RESP: begin
        if (dmem_rvalid) begin
          wb_valid_d = 1'b1;
          wb_rw_d    = regwrite_q;
          wb_m2r_d   = memtoreg_q;
          wb_rd_d    = rd_q;
          wb_alu_d   = alu_q;
          wb_mem_d   = load_extend(f3_q, alu_q[1:0], dmem_rdata);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_q      <= 32'd0;
      wdata_q    <= 32'd0;
      wstrb_q    <= 4'd0;
      f3_q       <= 3'd0;
      rd_q       <= 5'd0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      load_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_err_q   <= 1'b0;
      wb_rw_q    <= 1'b0;
      wb_m2r_q   <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_alu_q   <= 32'd0;
      wb_mem_q   <= 32'd0;
    end else begin
      alu_q      <= alu_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      f3_q       <= f3_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      load_q     <= load_d;
      wb_valid_q <= wb_valid_d;
      wb_err_q   <= wb_err_d;
      wb_rw_q    <= wb_rw_d;
      wb_m2r_q   <= wb_m2r_d;
      wb_rd_q    <= wb_rd_d;
      wb_alu_q   <= wb_alu_d;
      wb_mem_q   <= wb_mem_d;
    end
  end

  assign wb_valid       = wb_valid_q;
  assign wb_RegWrite    = wb_rw_q;
  assign wb_MemtoReg    = wb_m2r_q;
  assign wb_rd          = wb_rd_q;
  assign wb_alu_data    = wb_alu_q;
  assign wb_mem_data    = wb_mem_q;
  assign misaligned_err = wb_err_q;

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage -- directed bench for memory_stage. The bench plays the
// data memory itself, so every grant/response arrives on a fixed cycle.
module tb_memory_stage;

  localparam logic [3:0] C_MR  = 4'b1000;
  localparam logic [3:0] C_MW  = 4'b0100;
  localparam logic [3:0] C_RW  = 4'b0010;
  localparam logic [3:0] C_M2R = 4'b0001;

  logic        clk, rst, in_valid;
  logic [3:0]  control_in;
  logic [2:0]  funct3;
  logic [4:0]  rd_in;
  logic [31:0] alu_data, memory_data;
  logic        stall, dmem_req, dmem_we;
  logic [11:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid, wb_RegWrite, wb_MemtoReg;
  logic [4:0]  wb_rd;
  logic [31:0] wb_alu_data, wb_mem_data;
  logic        misaligned_err;

  int checks = 0;
  int errors = 0;

  memory_stage #(.DMEM_AW(12)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .control_in(control_in),
    .funct3(funct3), .rd_in(rd_in), .alu_data(alu_data), .memory_data(memory_data),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg), .wb_rd(wb_rd),
    .wb_alu_data(wb_alu_data), .wb_mem_data(wb_mem_data),
    .misaligned_err(misaligned_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [3:0] c, input logic [2:0] f,
                       input logic [4:0] r, input logic [31:0] a, input logic [31:0] d);
    in_valid = v; control_in = c; funct3 = f; rd_in = r; alu_data = a; memory_data = d;
  endtask

  task automatic test_reset;
    rst = 1'b1; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    drive(1'b0, 4'd0, 3'd0, 5'd0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    checks++;
    if ({stall, dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata} !== '0) begin
      errors++; $display("FAIL reset_dmem got stall=%0b req=%0b we=%0b addr=%h strb=%b wdata=%h exp all 0",
                         stall, dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata);
    end
    checks++;
    if ({wb_valid, wb_RegWrite, wb_MemtoReg, wb_rd, wb_alu_data, wb_mem_data, misaligned_err} !== '0) begin
      errors++; $display("FAIL reset_wb got valid=%0b rw=%0b m2r=%0b rd=%0d alu=%h mem=%h err=%0b exp all 0",
                         wb_valid, wb_RegWrite, wb_MemtoReg, wb_rd, wb_alu_data, wb_mem_data, misaligned_err);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_alu;
    drive(1'b1, C_RW, 3'd0, 5'd5, 32'h1234, 32'd0);
    @(negedge clk);
    drive(1'b0, 4'd0, 3'd0, 5'd0, 32'd0, 32'd0);
    checks++;
    if ({wb_valid, wb_RegWrite, wb_MemtoReg, misaligned_err, stall} !== 5'b11000) begin
      errors++; $display("FAIL alu_flags got valid=%0b rw=%0b m2r=%0b err=%0b stall=%0b exp 1 1 0 0 0",
                         wb_valid, wb_RegWrite, wb_MemtoReg, misaligned_err, stall);
    end
    checks++;
    if (wb_rd !== 5'd5 || wb_alu_data !== 32'h1234 || wb_mem_data !== 32'd0) begin
      errors++; $display("FAIL alu_data got rd=%0d alu=%h mem=%h exp 5 00001234 0", wb_rd, wb_alu_data, wb_mem_data);
    end
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0 || wb_rd !== 5'd5 || wb_alu_data !== 32'h1234) begin
      errors++; $display("FAIL alu_pulse got valid=%0b rd=%0d alu=%h exp 0 5 00001234", wb_valid, wb_rd, wb_alu_data);
    end
  endtask

  task automatic test_store_byte;
    int req_cycles = 0;
    drive(1'b1, C_MW, 3'b000, 5'd3, 32'h103, 32'hAABBCCDD);
    @(negedge clk);
    drive(1'b0, 4'd0, 3'd0, 5'd0, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      if (dmem_req === 1'b1) req_cycles++;
      checks++;
      if (dmem_we !== 1'b1 || dmem_addr !== 12'h100 || dmem_wstrb !== 4'b1000 ||
          dmem_wdata !== 32'hDDDDDDDD || stall !== 1'b1) begin
        errors++; $display("FAIL sb_req%0d got we=%0b addr=%h strb=%b wdata=%h stall=%0b exp 1 100 1000 dddddddd 1",
                           i, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata, stall);
      end
      if (i == 2) dmem_gnt = 1'b1;
      @(negedge clk);
    end
    dmem_gnt = 1'b0;
    checks++;
    if (req_cycles != 3 || dmem_req !== 1'b0) begin
      errors++; $display("FAIL sb_req_len got %0d cycles, req_after=%0b exp 3 cycles, 0", req_cycles, dmem_req);
    end
    checks++;
    if (wb_valid !== 1'b1 || wb_RegWrite !== 1'b0 || stall !== 1'b0 || wb_alu_data !== 32'h103) begin
      errors++; $display("FAIL sb_wb got valid=%0b rw=%0b stall=%0b alu=%h exp 1 0 0 00000103",
                         wb_valid, wb_RegWrite, stall, wb_alu_data);
    end
    @(negedge clk);
  endtask

  task automatic test_load_byte;
    logic [2:0]  f3v  [2];
    logic [31:0] expv [2];
    f3v[0] = 3'b000; expv[0] = 32'hFFFFFF80;
    f3v[1] = 3'b100; expv[1] = 32'h00000080;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, C_MR | C_RW | C_M2R, f3v[k], 5'd7, 32'h101, 32'd0);
      @(negedge clk);
      drive(1'b0, 4'd0, 3'd0, 5'd0, 32'd0, 32'd0);
      checks++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 12'h100 || dmem_wstrb !== 4'b0000) begin
        errors++; $display("FAIL lb%0d_req got req=%0b we=%0b addr=%h strb=%b exp 1 0 100 0000",
                           k, dmem_req, dmem_we, dmem_addr, dmem_wstrb);
      end
      dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (stall !== 1'b1 || dmem_req !== 1'b0 || wb_valid !== 1'b0) begin
          errors++; $display("FAIL lb%0d_wait%0d got stall=%0b req=%0b wbv=%0b exp 1 0 0",
                             k, i, stall, dmem_req, wb_valid);
        end
        @(negedge clk);
      end
      dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_8000;
      @(negedge clk);
      dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
      checks++;
      if (wb_valid !== 1'b1 || wb_mem_data !== expv[k] || wb_RegWrite !== 1'b1 ||
          wb_MemtoReg !== 1'b1 || wb_rd !== 5'd7 || stall !== 1'b0) begin
        errors++; $display("FAIL lb%0d_wb got valid=%0b mem=%h rw=%0b m2r=%0b rd=%0d stall=%0b exp 1 %h 1 1 7 0",
                           k, wb_valid, wb_mem_data, wb_RegWrite, wb_MemtoReg, wb_rd, stall, expv[k]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_half_and_misaligned;
    drive(1'b1, C_MR | C_RW | C_M2R, 3'b001, 5'd8, 32'h102, 32'd0);
    @(negedge clk);
    drive(1'b0, 4'd0, 3'd0, 5'd0, 32'd0, 32'd0);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h8001_0000;
    @(negedge clk);
    dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    checks++;
    if (wb_valid !== 1'b1 || wb_mem_data !== 32'hFFFF8001 || misaligned_err !== 1'b0) begin
      errors++; $display("FAIL lh_wb got valid=%0b mem=%h err=%0b exp 1 ffff8001 0",
                         wb_valid, wb_mem_data, misaligned_err);
    end
    // LW to 0x102, then a memory op with an unused funct3.
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, C_MR | C_RW | C_M2R, (k == 0) ? 3'b010 : 3'b011, 5'd9,
            (k == 0) ? 32'h102 : 32'h100, 32'd0);
      @(negedge clk);
      drive(1'b0, 4'd0, 3'd0, 5'd0, 32'd0, 32'd0);
      checks++;
      if (dmem_req !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b1 ||
          misaligned_err !== 1'b1 || wb_RegWrite !== 1'b0) begin
        errors++; $display("FAIL fault%0d got req=%0b stall=%0b wbv=%0b err=%0b rw=%0b exp 0 0 1 1 0",
                           k, dmem_req, stall, wb_valid, misaligned_err, wb_RegWrite);
      end
      @(negedge clk);
      checks++;
      if (misaligned_err !== 1'b0 || wb_valid !== 1'b0 || dmem_req !== 1'b0) begin
        errors++; $display("FAIL fault%0d_pulse got err=%0b wbv=%0b req=%0b exp 0 0 0",
                           k, misaligned_err, wb_valid, dmem_req);
      end
    end
  endtask

  task automatic test_reset_abort;
    drive(1'b1, C_MR | C_RW | C_M2R, 3'b010, 5'd4, 32'h200, 32'd0);
    @(negedge clk);
    drive(1'b0, 4'd0, 3'd0, 5'd0, 32'd0, 32'd0);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL abort_in_resp got stall=%0b exp 1", stall);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({stall, dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata, wb_valid, wb_RegWrite,
           wb_MemtoReg, wb_rd, wb_alu_data, wb_mem_data, misaligned_err} !== '0) begin
        errors++; $display("FAIL abort%0d got stall=%0b req=%0b wbv=%0b rw=%0b rd=%0d mem=%h alu=%h exp all 0",
                           i, stall, dmem_req, wb_valid, wb_RegWrite, wb_rd, wb_mem_data, wb_alu_data);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    drive(1'b1, C_MW, 3'b010, 5'd2, 32'h40, 32'h11223344);
    @(negedge clk);
    // Upstream now presents the next instruction and holds it while stalled.
    drive(1'b1, C_RW, 3'd0, 5'd9, 32'h55, 32'd0);
    checks++;
    if (dmem_req !== 1'b1 || dmem_wstrb !== 4'b1111 || dmem_wdata !== 32'h11223344 ||
        dmem_addr !== 12'h040 || stall !== 1'b1) begin
      errors++; $display("FAIL b2b_req got req=%0b strb=%b wdata=%h addr=%h stall=%0b exp 1 1111 11223344 040 1",
                         dmem_req, dmem_wstrb, dmem_wdata, dmem_addr, stall);
    end
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    checks++;
    if (wb_valid !== 1'b1 || wb_RegWrite !== 1'b0 || wb_alu_data !== 32'h40 || stall !== 1'b0) begin
      errors++; $display("FAIL b2b_store_wb got valid=%0b rw=%0b alu=%h stall=%0b exp 1 0 00000040 0",
                         wb_valid, wb_RegWrite, wb_alu_data, stall);
    end
    @(negedge clk);
    drive(1'b0, 4'd0, 3'd0, 5'd0, 32'd0, 32'd0);
    checks++;
    if (wb_valid !== 1'b1 || wb_RegWrite !== 1'b1 || wb_rd !== 5'd9 || wb_alu_data !== 32'h55) begin
      errors++; $display("FAIL b2b_alu_wb got valid=%0b rw=%0b rd=%0d alu=%h exp 1 1 9 00000055",
                         wb_valid, wb_RegWrite, wb_rd, wb_alu_data);
    end
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL b2b_idle got valid=%0b stall=%0b exp 0 0", wb_valid, stall);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store_byte();
    test_load_byte();
    test_half_and_misaligned();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
